// File: rtl/projection_sequencer.sv
// Purpose: sequences one BX of tracklets into the projection pipeline and writes results to projection memory.
// Latency: reads at cycles 1..n after start; writes follow PIPE_LAT cycles later; done one cycle after the last write.
// Backpressure: none downstream. With PROJ_STALL_EN defined, the stall input pauses issue while in-flight items drain.
module projection_sequencer #(
  parameter int NUM_TKL  = 63,
  parameter int PIPE_LAT = 6,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        bx,
  input  logic [6:0]        n_tracklet,
`ifdef PROJ_STALL_EN
  input  logic              stall,
`endif
  output logic [ADDR_W-1:0] read_tracklet,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] write_projection,
  output logic              wr_en,
  output logic [6:0]        n_projection,
  output logic              busy,
  output logic              done,
  output logic              start_err
);

  localparam int IDX_W = ADDR_W - 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [2:0]          bx_l;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    widx;
  logic [IDX_W-1:0]    last_idx;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [ADDR_W-1:0]   rd_hold;
  logic [ADDR_W-1:0]   wr_hold;
  logic [6:0]          cnt_req;
  logic                start_ok;
  logic                issue_stall;

`ifdef PROJ_STALL_EN
  assign issue_stall = stall;
`else
  assign issue_stall = 1'b0;
`endif

  // Requested count clamped to the per-BX maximum.
  assign cnt_req  = (n_tracklet > 7'(NUM_TKL)) ? 7'(NUM_TKL) : n_tracklet;
  assign start_ok = start && (state == IDLE);

  // Addresses are live while issuing/writing and hold their last value otherwise.
  assign read_tracklet    = rd_valid ? {bx_l, idx} : rd_hold;
  assign wr_en            = vld_sr[PIPE_LAT-1];
  assign write_projection = wr_en ? {bx_l, widx} : wr_hold;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus issue, busy and done strobes.
  always_comb begin
    state_nxt = state;
    rd_valid  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cnt_req != 7'd0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        if (!issue_stall) begin
          rd_valid = 1'b1;
          if (idx == last_idx) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Empty shift register means the final write happened last cycle.
        if (vld_sr == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Valid pipeline, index counters, address holds, projection count and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr       <= '0;
      bx_l         <= '0;
      idx          <= '0;
      widx         <= '0;
      last_idx     <= '0;
      rd_hold      <= '0;
      wr_hold      <= '0;
      n_projection <= '0;
      start_err    <= 1'b0;
    end else begin
      // Keeps advancing during stalls so in-flight items still complete.
      vld_sr <= (vld_sr << 1) | PIPE_LAT'(rd_valid);

      if (start && busy) begin
        start_err <= 1'b1;
      end

      if (start_ok) begin
        bx_l         <= bx;
        idx          <= '0;
        widx         <= '0;
        last_idx     <= IDX_W'(cnt_req - 7'd1);
        n_projection <= '0;
      end else begin
        if (rd_valid) begin
          idx     <= idx + 1'b1;
          rd_hold <= read_tracklet;
        end
        if (wr_en) begin
          widx         <= widx + 1'b1;
          wr_hold      <= write_projection;
          n_projection <= n_projection + 7'd1;
        end
      end
    end
  end

endmodule

// File: doc/projection_sequencer.md
Name: projection_sequencer

Overview:
- Controller that sequences the projection calculation datapath for one bunch crossing (BX) at a time.
- Per BX: reads up to NUM_TKL tracklets from the tracklet memory and issues them back-to-back into the fixed-latency projection pipeline.
- Generates the projection-memory write address and write enable aligned to pipeline output.
- Sits between the tracklet memory, the projection calculation pipeline and the projection memory.

Parameters:
- NUM_TKL, 63: maximum tracklets processed per BX; larger requested counts are clamped to this value.
- PIPE_LAT, 6: cycles from read_tracklet address issue to valid projection_calc at the pipeline output. Covers memory read latency plus calculation latency. Must be ≥1.
- ADDR_W, 9: memory address width. Address is {bx[2:0], index[5:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin processing a new BX
- bx  in  3  BX number, sampled with start
- n_tracklet  in  7  number of tracklets stored for this BX, sampled with start
- read_tracklet  out  9  tracklet memory read address
- rd_valid  out  1  read_tracklet is a live issue this cycle
- write_projection  out  9  projection memory write address
- wr_en  out  1  projection memory write enable, aligned to pipeline output
- n_projection  out  7  projections written for the current/last BX
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse: all writes of the BX complete
- start_err  out  1  sticky: start arrived while busy

Behaviour:
- Reset values:
  - read_tracklet = 0, write_projection = 0, n_projection = 0.
  - rd_valid, wr_en, busy, done, start_err = 0.
  - State machine in IDLE; valid shift register cleared.
  - Reset mid-operation abandons all in-flight items: no wr_en after reset.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - On start, latch bx and cnt = min(n_tracklet, NUM_TKL).
  - Clear n_projection.
  - Go to ISSUE if cnt > 0, otherwise go to DRAIN.
- ISSUE:
  - Every cycle: rd_valid = 1 and read_tracklet = {bx_l, idx}, with idx running 0..cnt-1.
  - After idx = cnt-1, go to DRAIN.
  - No bubbles unless stalled (see Optional Feature).
- Valid tracking:
  - rd_valid is fed into a PIPE_LAT-deep shift register; its output is wr_en.
  - While wr_en = 1: write_projection = {bx_l, widx}, widx starts at 0 and increments after each write; n_projection increments.
- DRAIN:
  - Wait until the shift register is empty.
  - done pulses for 1 cycle in the cycle after the last wr_en, then go to IDLE.
  - With cnt = 0, done pulses in the cycle after start.
- busy = 1 in ISSUE and DRAIN, and in the done cycle.
- Cycle timing (start at cycle 0, cnt = n):
  - Reads at cycles 1..n.
  - Writes at cycles 1+PIPE_LAT .. n+PIPE_LAT.
  - done at cycle n+PIPE_LAT+1.
- start while busy (including the done cycle): ignored, start_err set. start_err is cleared only by reset. A start in the cycle after done is accepted.
- Index counters are 6 bits and never wrap within a BX because cnt ≤ 63. bx is taken as-is; BX 7 followed by BX 0 needs no special handling.
- write_projection holds its last value when wr_en = 0. read_tracklet holds its last value when rd_valid = 0.

Optional Feature:
- Macro: PROJ_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall = 1 in ISSUE: no issue; rd_valid = 0; idx holds.
  - The shift register keeps advancing, so in-flight items still complete with correct wr_en.
  - stall has no effect in IDLE or DRAIN.
- Undefined: no stall port; issue is strictly back-to-back.

Test Plan:
- Basic run: reset, then start with bx=2, n_tracklet=3, PIPE_LAT=6 at cycle 0.
  - read_tracklet = 0x080, 0x081, 0x082 at cycles 1–3.
  - wr_en with write_projection 0x080–0x082 at cycles 7–9.
  - done at cycle 10; n_projection = 3.
- Zero and clamp: n_tracklet=0 → no rd_valid/wr_en, done at cycle 1. n_tracklet=100 → exactly 63 reads and 63 writes, last address {bx,6'd62}, n_projection = 63.
- Start while busy: second start during ISSUE → ignored, start_err = 1 and stays 1. A start in the cycle after done is accepted and processed normally.
- Reset mid-run: assert reset during DRAIN with 2 items in flight → no wr_en afterwards, busy = 0 and all outputs at reset values in the next cycle.
- Back-to-back BXs: bx=7 with n=2, then bx=0 with n=1 started right after done → addresses 0x1C0, 0x1C1, then 0x000; n_projection resets to 0 then counts to 1.
- PROJ_STALL_EN: n=4, stall held high for 2 cycles after the second issue → reads idx 0, 1, then a 2-cycle gap, then 2, 3. Write addresses stay contiguous 0..3, wr_en shows the same 2-cycle gap, done at cycle 4+2+PIPE_LAT+1.
